// File: rtl/program_loader_if.sv
// Byte-stream input and assembled-word output bundle of the program loader.
// The loader takes the slave side; the host/image source takes the master side.
interface program_loader_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] new_instruction;
    logic        add_into;
    logic        word_valid;
    logic [7:0]  word_addr;
    logic        start_signal;
    logic        error;

    modport master (
        output in_byte, in_valid,
        input  in_ready, new_instruction, add_into, word_valid, word_addr, start_signal, error
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, new_instruction, add_into, word_valid, word_addr, start_signal, error
    );
endinterface

// File: rtl/program_loader.sv
// Receives a program image (NI, ND, instruction words, data words, XOR checksum) byte by byte,
// emits big-endian 32-bit words with target addresses, then reports start or checksum error.
module program_loader #(
    parameter int DATA_TOP = 255
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        HDR_I  = 3'd0,
        HDR_D  = 3'd1,
        LOAD_I = 3'd2,
        LOAD_D = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [7:0] DATA_TOP_C = 8'(DATA_TOP);

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  ni_q, ni_d;
    logic [7:0]  nd_q, nd_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  csum_q, csum_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] new_instr_q, new_instr_d;
    logic        add_into_q, add_into_d;
    logic        word_valid_q, word_valid_d;
    logic [7:0]  word_addr_q, word_addr_d;
    logic        start_q, start_d;
    logic        error_q, error_d;
    logic        accept_s;
    logic        last_word_s;

    assign accept_s = bus.in_valid & in_ready_q;

    // Next-state, word assembly and checksum accumulation for every accepted byte.
    always_comb begin
        state_d      = state_q;
        ni_d         = ni_q;
        nd_d         = nd_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        csum_d       = csum_q;
        new_instr_d  = new_instr_q;
        add_into_d   = add_into_q;
        word_valid_d = 1'b0;
        word_addr_d  = word_addr_q;
        start_d      = start_q;
        error_d      = error_q;
        last_word_s  = 1'b0;

        if (accept_s) begin
            case (state_q)
                HDR_I: begin
                    ni_d    = bus.in_byte;
                    csum_d  = csum_step(csum_q, bus.in_byte);
                    state_d = HDR_D;
                end
                HDR_D: begin
                    nd_d       = bus.in_byte;
                    csum_d     = csum_step(csum_q, bus.in_byte);
                    word_cnt_d = 8'd0;
                    byte_cnt_d = 2'd0;
                    if (ni_q != 8'd0) begin
                        state_d = LOAD_I;
                    end else if (bus.in_byte != 8'd0) begin
                        state_d = LOAD_D;
                    end else begin
                        state_d = CHECK;
                    end
                end
                LOAD_I, LOAD_D: begin
                    csum_d     = csum_step(csum_q, bus.in_byte);
                    shift_d    = {shift_q[15:0], bus.in_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        new_instr_d  = {shift_q, bus.in_byte};
                        word_valid_d = 1'b1;
                        add_into_d   = add_into_q | (state_q == LOAD_D);
                        // Data memory fills downward from DATA_TOP, wrapping in 8 bits.
                        word_addr_d  = (state_q == LOAD_I) ? word_cnt_q : (DATA_TOP_C - word_cnt_q);
                        last_word_s  = (state_q == LOAD_I) ? (word_cnt_q == (ni_q - 8'd1))
                                                           : (word_cnt_q == (nd_q - 8'd1));
                        if (last_word_s) begin
                            word_cnt_d = 8'd0;
                            if (state_q == LOAD_I && nd_q != 8'd0) begin
                                state_d = LOAD_D;
                            end else begin
                                state_d = CHECK;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + 8'd1;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q;
                    end
                end
                CHECK: begin
                    if (bus.in_byte == csum_q) begin
                        state_d = DONE;
                        start_d = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
                DONE: state_d = DONE;
                ERR:  state_d = ERR;
                default: begin
                    state_d = ERR;
                    error_d = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        in_ready_d = (state_d != DONE) && (state_d != ERR);
    end

    // State and registered outputs; asynchronous active-low reset discards any partial image.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HDR_I;
            ni_q         <= 8'd0;
            nd_q         <= 8'd0;
            word_cnt_q   <= 8'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            csum_q       <= 8'd0;
            in_ready_q   <= 1'b0;
            new_instr_q  <= 32'd0;
            add_into_q   <= 1'b0;
            word_valid_q <= 1'b0;
            word_addr_q  <= 8'd0;
            start_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ni_q         <= ni_d;
            nd_q         <= nd_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            in_ready_q   <= in_ready_d;
            new_instr_q  <= new_instr_d;
            add_into_q   <= add_into_d;
            word_valid_q <= word_valid_d;
            word_addr_q  <= word_addr_d;
            start_q      <= start_d;
            error_q      <= error_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.new_instruction = new_instr_q;
    assign bus.add_into        = add_into_q;
    assign bus.word_valid      = word_valid_q;
    assign bus.word_addr       = word_addr_q;
    assign bus.start_signal    = start_q;
    assign bus.error           = error_q;

endmodule
